debounce_multi: RTL
===================

# debounce_multi

Parametrised, multi-channel debouncer for the board's mechanical inputs (buttons, switches) feeding the UART transmit-control and top-level logic. Each channel synchronises its raw input, filters bounce with its own stability counter and state machine, and presents a clean level plus optional one-cycle rise/fall pulses. It replaces per-signal single-bit debouncers with fixed timers and adds a configurable filter time, a channel count, a built-in synchroniser and edge outputs.

## Interface

- `CHANNELS`, 1: number of independent input channels.
- `DEBOUNCE_CYCLES`, 500_000: consecutive stable samples needed to change state (5 ms at 100 MHz); legal range 2..2^20.
- `SYNC_STAGES`, 2: synchroniser flops per channel; legal range 2..4.
- `clk`  input  1  system clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `noisy`  input  CHANNELS  raw asynchronous inputs.
- `debounced`  output  CHANNELS  filtered levels.
- `rise`  output  CHANNELS  one-cycle pulse on each debounced 0->1.
- `fall`  output  CHANNELS  one-cycle pulse on each debounced 1->0.

## Operation

- Per channel: `noisy[i]` passes through `SYNC_STAGES` flops; the last stage is `sync_in`.
- Per-channel counter, width `$clog2(DEBOUNCE_CYCLES)`; never shared between channels.
- Per-channel Moore FSM, states `LOW`, `ARM_HI`, `HIGH`, `ARM_LO`; `debounced` = 1 in `HIGH` and `ARM_LO`, else 0.
- `LOW`: `sync_in`=1 -> `ARM_HI`, cnt<=1; else stay, cnt<=0.
- `ARM_HI`: `sync_in`=0 -> `LOW`, cnt<=0; `sync_in`=1 and cnt==`DEBOUNCE_CYCLES`-1 -> `HIGH`, cnt<=0; else cnt<=cnt+1.
- `HIGH`: `sync_in`=0 -> `ARM_LO`, cnt<=1; else stay, cnt<=0.
- `ARM_LO`: mirror of `ARM_HI` (`sync_in`=1 -> `HIGH`; completion -> `LOW`).
- Any bounce during an `ARM_*` state restarts the filter from scratch; no partial credit is retained.
- Counter never exceeds `DEBOUNCE_CYCLES`-1; no wrap-around possible.
- `rise[i]` is registered: 1 for exactly the first cycle `debounced[i]` is 1 (set on the `ARM_HI`->`HIGH` edge, cleared next edge). `fall[i]` is the same for `ARM_LO`->`LOW`.
- Channels are fully independent; simultaneous transitions on several channels each produce their own pulses in the same cycle.
- No illegal-state recovery beyond reset; the enum's default branch forces `LOW`.

## Timing

- Reset (`reset_n`=0, asynchronous): all sync flops 0, FSM `LOW`, counters 0, `debounced`=0, `rise`=0, `fall`=0, regardless of the clock.
- Release: takes effect on the first `clk` rising edge with `reset_n`=1. A channel with `noisy` already high debounces to 1 normally and emits `rise`.
- Reset asserted mid-filter or mid-pulse: pulse truncated, state cleared immediately, no `fall` emitted.
- Latency: `noisy` held stable from edge 1 -> `debounced` changes after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`; `rise`/`fall` are high during that same cycle only.
- Minimum pulse width accepted: `DEBOUNCE_CYCLES` cycles; shorter glitches never reach `debounced`.

## Configuration

- `DEBOUNCE_PULSE_EN`: defined -> `rise`/`fall` registers are built as above. Undefined -> `rise` and `fall` are tied to 0 and their flops are not instantiated; `debounced` behaviour is identical.

## Structure

- `debounce_pkg`: `deb_state_t` enum (`LOW`, `ARM_HI`, `HIGH`, `ARM_LO`) and the limit constants `DEB_MAX_CYCLES` = 2^20 and `DEB_MAX_SYNC` = 4.
- Sub-module `debounce_channel`: synchroniser, counter, FSM and pulse flops for one bit. The top instantiates it `CHANNELS` times in a generate loop. Parameters are checked with elaboration-time assertions in the top.

## Test plan

All tests use `CHANNELS`=4, `DEBOUNCE_CYCLES`=4, `SYNC_STAGES`=2 and `DEBOUNCE_PULSE_EN` defined.

- Clean press: `noisy[0]` 0->1 held -> `debounced[0]`=1 after edge 6; `rise[0]`=1 for exactly that one cycle; other channels stay 0.
- Bounce: `noisy[1]` high 3 cycles, low 1 cycle, high held -> no output change until 4 stable samples after the last rise; exactly one `rise[1]`.
- Release: from `debounced[2]`=1, drop `noisy[2]` -> `debounced[2]`=0 after edge 6; single `fall[2]` pulse; a 2-cycle low glitch instead leaves it at 1.
- Simultaneous: `noisy`=4'b1111 in one cycle -> all four `debounced` bits and all four `rise` bits assert in the same cycle.
- Async reset mid-filter: `reset_n`=0 between edges while `ARM_HI` -> outputs 0 immediately without a clock edge. On release with `noisy` still high, `debounced`=1 after 6 edges.
- Macro off: rebuild without `DEBOUNCE_PULSE_EN`, repeat the clean press -> `debounced` timing unchanged; `rise`/`fall` are 0 throughout.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and limits for the multi-channel debouncer.
// Holds the per-channel filter state encoding and parameter ceilings.
package debounce_pkg;

   typedef enum logic [1:0] {
      LOW    = 2'd0,
      ARM_HI = 2'd1,
      HIGH   = 2'd2,
      ARM_LO = 2'd3
   } deb_state_t;

   localparam int unsigned DEB_MAX_CYCLES = 32'd1 << 20;
   localparam int unsigned DEB_MAX_SYNC   = 32'd4;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, stability counter, filter FSM and
// optional rise/fall pulse flops (built only when DEBOUNCE_PULSE_EN is set).
// Ports: clk, reset_n (async, active-low), noisy_i (raw async input),
//        debounced_o (filtered level), rise_o / fall_o (one-cycle pulses).
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500_000,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic noisy_i,
   output logic debounced_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_in;
   deb_state_t             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_i};
      end
   end

   assign sync_in = sync_q[SYNC_STAGES-1];

   // Entering an ARM state already counts the first stable sample,
   // hence cnt starts at 1 there.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         LOW: begin
            if (sync_in) begin
               state_d = ARM_HI;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         ARM_HI: begin
            if (!sync_in) begin
               state_d = LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HIGH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HIGH: begin
            if (!sync_in) begin
               state_d = ARM_LO;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         ARM_LO: begin
            if (sync_in) begin
               state_d = HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = LOW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = LOW;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= LOW;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign debounced_o = (state_q == HIGH) || (state_q == ARM_LO);

`ifdef DEBOUNCE_PULSE_EN
   logic rise_q, rise_d;
   logic fall_q, fall_d;

   assign rise_d = (state_q == ARM_HI) && (state_d == HIGH);
   assign fall_d = (state_q == ARM_LO) && (state_d == LOW);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;
`else
   assign rise_o = 1'b0;
   assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer top: CHANNELS independent debounce_channel slices.
// Ports: clk, reset_n (async, active-low), noisy[CHANNELS] in,
//        debounced / rise / fall [CHANNELS] out. Macro: DEBOUNCE_PULSE_EN.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int unsigned CHANNELS        = 1,
   parameter int unsigned DEBOUNCE_CYCLES = 500_000,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] noisy,
   output logic [CHANNELS-1:0] debounced,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall
);

   if (CHANNELS < 1) begin : g_bad_ch
      $error("debounce_multi: CHANNELS must be >= 1");
   end
   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > DEB_MAX_CYCLES) begin : g_bad_cyc
      $error("debounce_multi: DEBOUNCE_CYCLES out of range");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > DEB_MAX_SYNC) begin : g_bad_sync
      $error("debounce_multi: SYNC_STAGES out of range");
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES)
      ) u_ch (
         .clk         (clk),
         .reset_n     (reset_n),
         .noisy_i     (noisy[i]),
         .debounced_o (debounced[i]),
         .rise_o      (rise[i]),
         .fall_o      (fall[i])
      );
   end

endmodule
